// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 register-access path: caddr field layout,
// socket register offsets and the bus arbiter state encoding.
package w5300_pkg;

  localparam int CADDR_W = 12;
  localparam int DATA_W  = 16;
  localparam int SEL_BIT = 11;
  localparam int OP_BIT  = 10;
  localparam int ADDR_W  = 10;

  localparam logic ADDR_S_VALID   = 1'b0;
  localparam logic ADDR_S_INVALID = 1'b1;
  localparam logic ADDR_OP_RD     = 1'b1;
  localparam logic ADDR_OP_WR     = 1'b0;

  localparam logic [ADDR_W-1:0] SN_CR       = 10'h202;
  localparam logic [ADDR_W-1:0] SN_SSR      = 10'h208;
  localparam logic [ADDR_W-1:0] SN_DPORTR   = 10'h212;
  localparam logic [ADDR_W-1:0] SN_DIPR     = 10'h214;
  localparam logic [ADDR_W-1:0] SN_WRSR     = 10'h220;
  localparam logic [ADDR_W-1:0] SN_TX_FSR   = 10'h224;
  localparam logic [ADDR_W-1:0] SN_TX_FIFOR = 10'h22E;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_e;

  function automatic logic [CADDR_W-1:0] caddr_with_sel(input logic [CADDR_W-1:0] c,
                                                        input logic sel);
    return {sel, c[CADDR_W-2:0]};
  endfunction

endpackage

// File: rtl/w5300_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr,
// wrapping around, so the previous owner has lowest priority.
module w5300_rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       valid
);

  localparam int PTR_W = $clog2(NUM_REQ);

  int                idx;
  logic [PTR_W-1:0]  idx_l;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // modulo keeps a stale out-of-range pointer from selecting a phantom slot
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_l = PTR_W'(idx);
      if (!valid && req[idx_l]) begin
        valid      = 1'b1;
        gnt[idx_l] = 1'b1;
        gnt_idx    = idx_l;
      end
    end
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 register-access bus between
// requesters, with locked bursts and a per-transaction completion timeout.
//
// state      | meaning
// ARB_IDLE   | bus invalid, arbitrate among pending requests
// ARB_ACTIVE | transaction issued, waiting for op_status or timeout
// ARB_GAP    | one forced invalid cycle; reissue if owner is locked
module w5300_bus_arbiter
  import w5300_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      lock,
  input  logic [NUM_REQ*12-1:0]   req_caddr,
  input  logic [NUM_REQ*16-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    xfer_err,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy,
  output logic                    timeout_sticky,
  output logic [CADDR_W-1:0]      caddr,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    op_status,
  input  logic [DATA_W-1:0]       bus_rd_data
);

  localparam int   PTR_W    = $clog2(NUM_REQ);
  localparam bit   TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int   TMR_W    = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int   TMO_LAST = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_LAST);

  logic [CADDR_W-1:0] caddr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign caddr_arr[gi] = req_caddr[12*gi +: 12];
    assign wdata_arr[gi] = req_wr_data[16*gi +: 16];
  end

  arb_state_e          state, state_nx;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_nx;
  logic [PTR_W-1:0]    own, own_nx;
  logic [TMR_W-1:0]    timer, timer_nx;
  logic [NUM_REQ-1:0]  grant_nx, done_nx;
  logic                xfer_err_nx, sticky_nx;
  logic [DATA_W-1:0]   rd_data_nx, wr_data_nx;
  logic [CADDR_W-1:0]  caddr_nx;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;

  w5300_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    own_nx      = own;
    timer_nx    = timer;
    grant_nx    = grant;
    done_nx     = '0;
    xfer_err_nx = xfer_err;
    sticky_nx   = timeout_sticky;
    rd_data_nx  = rd_data;
    wr_data_nx  = wr_data;
    caddr_nx    = caddr;

    case (state)
      ARB_IDLE: begin
        caddr_nx = caddr_with_sel(caddr, ADDR_S_INVALID);
        if (pick_valid) begin
          grant_nx   = pick_gnt;
          own_nx     = pick_idx;
          rr_ptr_nx  = pick_idx;
          caddr_nx   = caddr_with_sel(caddr_arr[pick_idx], ADDR_S_VALID);
          wr_data_nx = wdata_arr[pick_idx];
          timer_nx   = '0;
          state_nx   = ARB_ACTIVE;
        end
      end

      ARB_ACTIVE: begin
        if (timer != '1) begin
          timer_nx = timer + 1'b1;
        end
        // completion beats a timeout landing on the same cycle
        if (op_status) begin
          done_nx     = grant;
          rd_data_nx  = bus_rd_data;
          xfer_err_nx = 1'b0;
          caddr_nx    = caddr_with_sel(caddr, ADDR_S_INVALID);
          state_nx    = ARB_GAP;
        end else if (TMO_EN && timer == TMR_LAST) begin
          done_nx     = grant;
          xfer_err_nx = 1'b1;
          sticky_nx   = 1'b1;
          caddr_nx    = caddr_with_sel(caddr, ADDR_S_INVALID);
          state_nx    = ARB_GAP;
        end
      end

      ARB_GAP: begin
        if (lock[own] && req[own]) begin
          caddr_nx   = caddr_with_sel(caddr_arr[own], ADDR_S_VALID);
          wr_data_nx = wdata_arr[own];
          timer_nx   = '0;
          state_nx   = ARB_ACTIVE;
        end else begin
          grant_nx = '0;
          state_nx = ARB_IDLE;
        end
      end

      default: begin
        grant_nx = '0;
        caddr_nx = caddr_with_sel(caddr, ADDR_S_INVALID);
        state_nx = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB_IDLE;
      rr_ptr         <= PTR_W'(NUM_REQ - 1);
      own            <= '0;
      timer          <= '0;
      grant          <= '0;
      done           <= '0;
      xfer_err       <= 1'b0;
      timeout_sticky <= 1'b0;
      rd_data        <= '0;
      wr_data        <= '0;
      caddr          <= {ADDR_S_INVALID, ADDR_OP_RD, {ADDR_W{1'b0}}};
    end else begin
      state          <= state_nx;
      rr_ptr         <= rr_ptr_nx;
      own            <= own_nx;
      timer          <= timer_nx;
      grant          <= grant_nx;
      done           <= done_nx;
      xfer_err       <= xfer_err_nx;
      timeout_sticky <= sticky_nx;
      rd_data        <= rd_data_nx;
      wr_data        <= wr_data_nx;
      caddr          <= caddr_nx;
    end
  end

  assign busy = (state != ARB_IDLE) || (grant != '0);

endmodule
